// File: rtl/prog_ctr_pkg.sv
// Shared types for the program counter / fetch sequencer.
// Select encodings are also consumed by the decoder's debug trace.
package prog_ctr_pkg;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        ABS  = 3'd2,
        REL  = 3'd3,
        INC  = 3'd4
    } pc_sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (wins over enable); one-cycle latency.
// No backpressure: counts every enabled cycle and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/prog_ctr.sv
// Program counter, run/halt FSM and RUN-cycle counter; all outputs registered, one-cycle latency.
// No backpressure: Stall holds the PC but still counts as a RUN cycle.
module prog_ctr #(
    parameter int              PC_W       = prog_ctr_pkg::PC_W,
    parameter int              CNT_W      = prog_ctr_pkg::CNT_W,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BrAbs,
    input  logic             BrRel,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    import prog_ctr_pkg::*;

    pc_state_t       state_q, state_d;
    pc_sel_t         pc_sel;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            cnt_clr;
    logic            cnt_en;

    // Start overrides everything, including Halt in the same cycle.
    always_comb begin
        state_d = state_q;
        pc_sel  = HOLD;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (Start) begin
            state_d = RUN;
            pc_sel  = LOAD;
            cnt_clr = 1'b1;
        end else if (state_q == RUN) begin
            cnt_en = 1'b1;
            if (Halt) begin
                state_d = DONE;
                pc_sel  = HOLD;
            end else if (Stall) begin
                pc_sel = HOLD;
            end else if (BrAbs && Taken) begin
                pc_sel = ABS;
            end else if (BrRel && Taken) begin
                pc_sel = REL;
            end else begin
                pc_sel = INC;
            end
        end
    end

    // Target only reaches the PC on a taken branch, so X elsewhere is harmless.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            HOLD:    pc_d = pc_q;
            LOAD:    pc_d = START_ADDR;
            ABS:     pc_d = Target;
            REL:     pc_d = pc_q + Target;
            INC:     pc_d = pc_q + 1'b1;
            default: pc_d = pc_q;
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_ADDR;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (CycleCnt)
    );

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: directed scenarios plus randomized traffic against an abstract model.
module tb_prog_ctr;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start, Halt, Stall, BrAbs, BrRel, Taken;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic       Running, Done;
    logic [15:0] CycleCnt;

    prog_ctr dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Halt     (Halt),
        .Stall    (Stall),
        .BrAbs    (BrAbs),
        .BrRel    (BrRel),
        .Taken    (Taken),
        .Target   (Target),
        .ProgCtr  (ProgCtr),
        .Running  (Running),
        .Done     (Done),
        .CycleCnt (CycleCnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          tag;
        logic [9:0]  pc;
        logic        run;
        logic        dn;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: program state as plain integers.
    int m_pc, m_cnt;
    bit m_run, m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.tag = cyc + 1;
        e.pc  = m_pc[9:0];
        e.run = m_run;
        e.dn  = m_done;
        e.cnt = m_cnt[15:0];
        exp_q.push_back(e);
    endtask

    // Called at posedge+1: drive inputs for the coming edge, predict, advance.
    task automatic step(input bit s, input bit h, input bit st, input bit a,
                        input bit r, input bit t, input logic [9:0] tg);
        int off;
        Start = s; Halt = h; Stall = st; BrAbs = a; BrRel = r; Taken = t; Target = tg;
        if (s) begin
            m_pc = 0; m_cnt = 0; m_run = 1; m_done = 0;
        end else if (m_run) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (h) begin
                m_run = 0; m_done = 1;
            end else if (!st) begin
                if (a && t) begin
                    m_pc = int'(tg);
                end else if (r && t) begin
                    off  = (int'(tg) >= 512) ? int'(tg) - 1024 : int'(tg);
                    m_pc = (m_pc + off + 1024) % 1024;
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end
        push_exp();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 10'h000);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic mid_reset();
        model_reset();
        push_exp();
        #4 Reset = 1'b0;
        #1;
        check("async_rst_pc",  ProgCtr,  10'h000);
        check("async_rst_run", Running,  1'b0);
        check("async_rst_done", Done,    1'b0);
        check("async_rst_cnt", CycleCnt, 16'h0000);
        @(posedge Clk);
        #1 Reset = 1'b1;
    endtask

    // Monitor: compares registered outputs against the expectation tagged for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
                e = exp_q.pop_front();
                check("sb_tag",  e.tag, cyc);
                check("sb_pc",   ProgCtr,  e.pc);
                check("sb_run",  Running,  e.run);
                check("sb_done", Done,     e.dn);
                check("sb_cnt",  CycleCnt, e.cnt);
            end
        end
    end

    initial begin
        int         c0;
        bit         s, h, st, a, r, t;
        logic [9:0] tg;

        Reset = 1'b0;
        Start = 0; Halt = 0; Stall = 0; BrAbs = 0; BrRel = 0; Taken = 0; Target = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_pc",   ProgCtr,  10'h000);
        check("reset_run",  Running,  1'b0);
        check("reset_done", Done,     1'b0);
        check("reset_cnt",  CycleCnt, 16'h0000);
        Reset = 1'b1;

        idle(2);
        check("idle_hold_pc", ProgCtr, 10'h000);
        check("idle_run",     Running, 1'b0);

        step(1, 0, 0, 0, 0, 0, 10'h000);
        check("start_pc",  ProgCtr, 10'h000);
        check("start_run", Running, 1'b1);
        idle(5);
        check("inc5_pc",  ProgCtr,  10'h005);
        check("inc5_cnt", CycleCnt, 16'd5);

        step(0, 0, 0, 1, 0, 1, 10'h010);
        step(0, 0, 0, 1, 0, 1, 10'h06D);
        check("abs_taken", ProgCtr, 10'h06D);
        step(0, 0, 0, 1, 0, 1, 10'h010);
        step(0, 0, 0, 1, 0, 0, 10'h06D);
        check("abs_not_taken", ProgCtr, 10'h011);

        step(0, 0, 0, 1, 0, 1, 10'h002);
        step(0, 0, 0, 0, 1, 1, 10'h3FC);
        check("rel_neg_wrap", ProgCtr, 10'h3FE);
        step(0, 0, 0, 0, 0, 0, 10'bx);
        check("inc_3ff", ProgCtr, 10'h3FF);
        step(0, 0, 0, 0, 0, 0, 10'bx);
        check("inc_wrap", ProgCtr, 10'h000);

        step(0, 0, 0, 1, 0, 1, 10'h020);
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 1, 10'h3AA);
        check("stall_pc",  ProgCtr,  10'h020);
        check("stall_cnt", CycleCnt, c0 + 3);
        step(0, 0, 0, 1, 1, 1, 10'h009);
        check("abs_over_rel", ProgCtr, 10'h009);

        step(1, 0, 0, 0, 0, 0, 10'h000);
        idle(6);
        step(0, 1, 0, 0, 0, 0, 10'h000);
        check("halt_done", Done,     1'b1);
        check("halt_run",  Running,  1'b0);
        check("halt_cnt",  CycleCnt, 16'd7);
        idle(10);
        check("done_pc",  ProgCtr,  10'h006);
        check("done_cnt", CycleCnt, 16'd7);
        step(1, 0, 0, 0, 0, 0, 10'h000);
        check("restart_pc",  ProgCtr,  10'h000);
        check("restart_cnt", CycleCnt, 16'd0);
        check("restart_run", Running,  1'b1);

        step(1, 1, 0, 0, 0, 0, 10'h000);
        check("start_over_halt", Running, 1'b1);

        step(0, 0, 0, 1, 0, 1, 10'h055);
        check("pc_055", ProgCtr, 10'h055);
        mid_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
            end else begin
                s  = ($urandom_range(0, 39) == 0);
                h  = ($urandom_range(0, 29) == 0);
                st = ($urandom_range(0, 3) == 0);
                a  = ($urandom_range(0, 3) == 0);
                r  = ($urandom_range(0, 3) == 0);
                t  = $urandom_range(0, 1);
                tg = 10'($urandom);
                if (!(t && (a || r)) && $urandom_range(0, 1) == 1) tg = 10'bx;
                step(s, h, st, a, r, t, tg);
            end
        end

        step(1, 0, 0, 0, 0, 0, 10'h000);
        for (int i = 0; i < 65540; i++) begin
            st = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 7) == 0);
            t  = $urandom_range(0, 1);
            tg = 10'($urandom);
            step(0, 0, st, a, r, t, tg);
        end
        check("sat_cnt", CycleCnt, 16'hFFFF);
        check("sat_run", Running,  1'b1);

        Start = 0; Halt = 0; Stall = 0; BrAbs = 0; BrRel = 0; Taken = 0;
        repeat (3) @(posedge Clk);
        #5;
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program counter and fetch sequencer for the 9-bit processor. Holds the 10-bit instruction address and drives instruction memory. Consumes the 10-bit `Target` produced by the branch-target lookup table and applies it as an absolute jump or a PC-relative offset. Implements the run/halt state machine and a saturating cycle counter used for benchmark reporting.

## Interface
- `PC_W`, 10: program counter width. Must equal the lookup-table `Target` width.
- `CNT_W`, 16: cycle counter width.
- `START_ADDR`, 10'h000: PC value loaded on `Start`.

- `Clk`  input  1  system clock; all state changes on rising edge.
- `Reset`  input  1  asynchronous, active-low reset. Clears all state immediately on assertion.
- `Start`  input  1  one-cycle pulse; begins program execution.
- `Halt`  input  1  decoded halt instruction; ends execution.
- `Stall`  input  1  hold PC for this cycle.
- `BrAbs`  input  1  absolute branch requested by current instruction.
- `BrRel`  input  1  relative branch requested by current instruction.
- `Taken`  input  1  branch condition result (ALU flag).
- `Target`  input  PC_W  lookup-table output for current instruction.
- `ProgCtr`  output  PC_W  current instruction address.
- `Running`  output  1  high in RUN.
- `Done`  output  1  high in DONE.
- `CycleCnt`  output  CNT_W  cycles spent in RUN, saturating.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: PC held. `Start` moves to RUN with PC ← START_ADDR and CycleCnt ← 0.
  - RUN: PC updates each cycle by the priority rule below. CycleCnt increments by 1 per RUN cycle and saturates at all-ones.
  - RUN with `Halt` high moves to DONE. PC and CycleCnt freeze at their pre-edge values plus the final count.
  - DONE: holds all state. `Start` restarts exactly as from IDLE.
- `Start` while in RUN restarts: PC ← START_ADDR, CycleCnt ← 0, stays in RUN. `Start` takes priority over `Halt` in the same cycle.
- PC next-value priority in RUN, highest first:
  - `Halt`: hold.
  - `Stall`: hold.
  - `BrAbs & Taken`: PC ← `Target`.
  - `BrRel & Taken`: PC ← PC + `Target`, with `Target` as two's-complement signed, truncated mod 2^PC_W.
  - otherwise: PC ← PC + 1, mod 2^PC_W.
- `BrAbs` and `BrRel` both high with `Taken`: the absolute branch wins.
- A branch request with `Taken` low increments the PC normally.
- Wrap-around: PC 10'h3FF + 1 gives 10'h000. PC 10'h002 + 10'h3FC (−4) gives 10'h3FE. Neither case is flagged.
- Stall cycles count toward CycleCnt. The Halt cycle counts; DONE cycles do not.
- `Target` is sampled only when a taken branch is selected. X on `Target` at other times must not propagate to `ProgCtr`.

## Timing
- Reset values, applied asynchronously: state IDLE, `ProgCtr` = START_ADDR, `CycleCnt` = 0, `Running` = 0, `Done` = 0.
- Reset asserted mid-RUN returns the block to IDLE immediately. Deassertion is synchronized externally; the first active edge after deassertion is a normal cycle.
- `ProgCtr`, `Running`, `Done` and `CycleCnt` are registered outputs with no combinational path from inputs.
- One-cycle latency: control inputs sampled at edge N take effect on the outputs after edge N.
- `Start` at edge N gives `Running` = 1 and `ProgCtr` = START_ADDR after edge N. The instruction at START_ADDR is decoded in cycle N+1.
- The branch decision uses the `Target` and `Taken` presented in the same cycle as the branch instruction. The PC reflects the branch after the next edge, with no delay slot.

## Structure
- Package `prog_ctr_pkg` holds:
  - the state enum `pc_state_t` {IDLE, RUN, DONE}
  - `PC_W`
  - the next-PC select enum {HOLD, LOAD, ABS, REL, INC}, shared with the decoder's debug trace.
- One sub-module, `sat_counter` (parameter width, synchronous clear, enable, async active-low reset). It implements CycleCnt and is reused elsewhere.
- Next-PC mux and FSM stay in `prog_ctr`.

## Test plan
- Reset then `Start`: `ProgCtr` = 0, `Running` = 1. After 5 idle-input cycles, `ProgCtr` = 5 and `CycleCnt` = 5.
- At PC 10'h010, `BrAbs`, `Taken`, `Target` = 10'h06D: next `ProgCtr` = 10'h06D. Repeat with `Taken` = 0: next `ProgCtr` = 10'h011.
- At PC 10'h002, `BrRel`, `Taken`, `Target` = 10'h3FC: next `ProgCtr` = 10'h3FE. At PC 10'h3FF with no branch: next `ProgCtr` = 10'h000.
- `Stall` plus `BrAbs`/`Taken` held 3 cycles at PC 10'h020: PC stays 10'h020 and `CycleCnt` still advances by 3. Then `BrAbs` and `BrRel` both high, `Taken`, `Target` = 10'h009: PC = 10'h009.
- `Halt` at cycle 7 of RUN: `Done` = 1, `Running` = 0, PC and `CycleCnt` = 7 frozen for 10 cycles. Then `Start`: PC = 0, `CycleCnt` = 0, `Running` = 1.
- `Reset` asserted mid-cycle during RUN at PC 10'h055: outputs go to reset values before the next edge. Separately, force `CycleCnt` near all-ones and confirm it saturates at 16'hFFFF.
